// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared helpers for the axis width converters
package axis_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Slot index width: clog2 of the slot count, never narrower than one bit.
  function automatic int slot_w(input int nb);
    return (clog2(nb) < 1) ? 1 : clog2(nb);
  endfunction

  // Count of contiguous ones in keep starting at bit 0, looking at nb bits.
  function automatic int lead_ones(input logic [31:0] keep, input int nb);
    int  cnt;
    bit  stop;
    cnt  = 0;
    stop = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < nb && !stop) begin
        if (keep[i]) cnt++;
        else         stop = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_serializer.sv
// rtl/axis_serializer.sv - wide-to-narrow AXI-Stream converter, slot 0 first
module axis_serializer
  import axis_pkg::*;
#(
  parameter int DATA_NB    = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
  input  logic [DATA_NB-1:0]            up_keep,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic                          up_last,
  output logic [DATA_WIDTH-1:0]         down_data,
  output logic                          down_valid,
  input  logic                          down_ready,
  output logic                          down_last
);

  localparam int SLOT_W = slot_w(DATA_NB);
  localparam int WORD_W = DATA_NB * DATA_WIDTH;

  logic [WORD_W-1:0]     word_q, word_d;
  // The count is held as its last slot index so it fits in SLOT_W bits for any DATA_NB.
  logic [SLOT_W-1:0]     last_idx_q, last_idx_d;
  logic [SLOT_W-1:0]     idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] down_data_q, down_data_d;
  logic                  down_valid_q, down_valid_d;
  logic                  down_last_q, down_last_d;

  logic                  up_fire;
  logic                  down_fire;
  logic [SLOT_W-1:0]     idx_nxt;
  logic [SLOT_W-1:0]     keep_last_idx;
  int                    keep_cnt;

  assign up_ready   = rst && (!busy_q || (down_ready && down_valid_q && idx_q == last_idx_q));
  assign up_fire    = up_valid && up_ready;
  assign down_fire  = down_valid_q && down_ready;
  assign down_data  = down_data_q;
  assign down_valid = down_valid_q;
  assign down_last  = down_last_q;

  always_comb begin
    word_d        = word_q;
    last_idx_d    = last_idx_q;
    idx_d         = idx_q;
    last_d        = last_q;
    busy_d        = busy_q;
    down_data_d   = down_data_q;
    down_valid_d  = down_valid_q;
    down_last_d   = down_last_q;
    idx_nxt       = idx_q + 1'b1;
    keep_cnt      = lead_ones(32'(up_keep), DATA_NB);
    keep_last_idx = (keep_cnt == 0) ? '0 : SLOT_W'(keep_cnt - 1);

    if (up_fire) begin
      word_d       = up_data;
      last_idx_d   = keep_last_idx;
      last_d       = up_last;
      idx_d        = '0;
      busy_d       = 1'b1;
      down_valid_d = 1'b1;
      down_data_d  = up_data[DATA_WIDTH-1:0];
      down_last_d  = up_last && (keep_last_idx == '0);
    end else if (down_fire) begin
      if (idx_q != last_idx_q) begin
        idx_d       = idx_nxt;
        down_data_d = word_q[idx_nxt*DATA_WIDTH +: DATA_WIDTH];
        down_last_d = last_q && (idx_nxt == last_idx_q);
      end else begin
        busy_d       = 1'b0;
        down_valid_d = 1'b0;
        down_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q       <= '0;
      last_idx_q   <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      down_data_q  <= '0;
      down_valid_q <= 1'b0;
      down_last_q  <= 1'b0;
    end else begin
      word_q       <= word_d;
      last_idx_q   <= last_idx_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      down_data_q  <= down_data_d;
      down_valid_q <= down_valid_d;
      down_last_q  <= down_last_d;
    end
  end

endmodule

// File: tb/tb_axis_serializer.sv
// tb/tb_axis_serializer.sv - self-checking bench for axis_serializer
module tb_axis_serializer;

  localparam int NB = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB*W-1:0] up_data;
  logic [NB-1:0] up_keep;
  logic          up_valid;
  logic          up_ready;
  logic          up_last;
  logic [W-1:0]  down_data;
  logic          down_valid;
  logic          down_ready;
  logic          down_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [NB*W-1:0] stim_data[$];
  logic [NB-1:0]   stim_keep[$];
  logic            stim_last[$];
  logic [W-1:0]    exp_data[$];
  logic            exp_last[$];
  logic [W-1:0]    got_data[$];
  logic            got_last[$];
  int              got_cyc[$];

  axis_serializer #(.DATA_NB(NB), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_keep    (up_keep),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_last    (up_last),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_last  (down_last)
  );

  always #5 clk = ~clk;

  // Reference: emit the leading contiguous kept slots (at least slot 0), lowest first.
  task automatic add_word(input logic [NB*W-1:0] d, input logic [NB-1:0] k, input logic l);
    int n;
    logic [NB*W-1:0] w;
    n = 0;
    while (n < NB && k[n]) n++;
    if (n == 0) n = 1;
    stim_data.push_back(d);
    stim_keep.push_back(k);
    stim_last.push_back(l);
    w = d;
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(w[W-1:0]);
      exp_last.push_back(l && (i == n - 1));
      w = w >> W;
    end
  endtask

  task automatic run_stream(input string name, input int mode, output int accept_cyc);
    int         guard;
    bit         held;
    logic [W-1:0] hd;
    logic       hl;
    bit         pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    guard = 0;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    accept_cyc = -1;
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    while ((stim_data.size() > 0 || got_data.size() < exp_data.size()) && guard < 2000) begin
      @(negedge clk);
      if (stim_data.size() > 0) begin
        up_valid = 1'b1;
        up_data  = stim_data[0];
        up_keep  = stim_keep[0];
        up_last  = stim_last[0];
      end else begin
        up_valid = 1'b0;
        up_data  = NB*W'($urandom);
        up_keep  = NB'($urandom);
        up_last  = 1'($urandom);
      end
      case (mode)
        0:       down_ready = 1'b1;
        1:       down_ready = pat[guard % 6];
        default: down_ready = ($urandom % 4) != 0;
      endcase
      #1;
      if (held) begin
        total_cnt++;
        if (down_valid !== 1'b1 || down_data !== hd || down_last !== hl)
          $display("FAIL %s hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   name, down_valid, down_data, down_last, hd, hl);
        else pass_cnt++;
        held = 1'b0;
      end
      if (down_valid && !down_ready) begin
        held = 1'b1;
        hd = down_data;
        hl = down_last;
      end
      if (down_valid && down_ready) begin
        got_data.push_back(down_data);
        got_last.push_back(down_last);
        got_cyc.push_back(guard);
      end
      if (up_valid && up_ready) begin
        if (accept_cyc < 0) accept_cyc = guard;
        void'(stim_data.pop_front());
        void'(stim_keep.pop_front());
        void'(stim_last.pop_front());
      end
      guard++;
    end
    @(negedge clk);
    up_valid = 1'b0;
    total_cnt++;
    if (guard >= 2000 || got_data.size() != exp_data.size())
      $display("FAIL %s beat count: got %0d required %0d (cycles %0d)",
               name, got_data.size(), exp_data.size(), guard);
    else pass_cnt++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total_cnt++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("FAIL %s beat %0d: got d=%h l=%b required d=%h l=%b",
                 name, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    stim_data.delete();
    stim_keep.delete();
    stim_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    up_valid = 1'b1;
    up_data = 24'h030201;
    up_keep = 3'b111;
    up_last = 1'b0;
    down_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (up_ready !== 1'b0 || down_valid !== 1'b0)
        $display("FAIL reset hold cycle %0d: got up_ready=%b down_valid=%b required 0 0",
                 i, up_ready, down_valid);
      else pass_cnt++;
    end
    @(negedge clk);
    up_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (up_ready !== 1'b1) $display("FAIL reset release up_ready: got %b required 1", up_ready);
    else pass_cnt++;
    total_cnt++;
    if (down_data !== 8'h00 || down_last !== 1'b0)
      $display("FAIL reset outputs: got d=%h l=%b required d=00 l=0", down_data, down_last);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (down_valid !== 1'b0) $display("FAIL reset idle valid: got %b required 0", down_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_continuous();
    int acc;
    add_word(24'h030201, 3'b111, 1'b0);
    add_word(24'h060504, 3'b111, 1'b0);
    run_stream("continuous", 0, acc);
    for (int i = 0; i < got_cyc.size(); i++) begin
      total_cnt++;
      if (got_cyc[i] !== acc + 1 + i)
        $display("FAIL continuous timing beat %0d: got cycle %0d required %0d", i, got_cyc[i], acc + 1 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    add_word(24'h030201, 3'b111, 1'b0);
    add_word(24'h060504, 3'b111, 1'b0);
    run_stream("backpressure", 1, acc);
  endtask

  task automatic test_partial_last();
    int acc;
    add_word(24'h000B0A, 3'b011, 1'b1);
    add_word(24'h0E0D0C, 3'b111, 1'b0);
    run_stream("partial_last", 0, acc);
  endtask

  task automatic test_degenerate();
    int acc;
    add_word(24'h3F2F1F, 3'b000, 1'b1);
    add_word(24'h5A4B3C, 3'b101, 1'b0);
    run_stream("degenerate", 1, acc);
  endtask

  task automatic test_reset_mid();
    int acc;
    @(negedge clk);
    up_valid = 1'b1;
    up_data = 24'h030201;
    up_keep = 3'b111;
    up_last = 1'b0;
    down_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    total_cnt++;
    if (down_valid !== 1'b1 || down_data !== 8'h01)
      $display("FAIL reset_mid first beat: got v=%b d=%h required v=1 d=01", down_valid, down_data);
    else pass_cnt++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (down_valid !== 1'b0 || up_ready !== 1'b0 || down_last !== 1'b0)
      $display("FAIL reset_mid async: got v=%b rdy=%b l=%b required 0 0 0", down_valid, up_ready, down_last);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0)
      $display("FAIL reset_mid release: got rdy=%b v=%b required 1 0", up_ready, down_valid);
    else pass_cnt++;
    add_word(24'h090807, 3'b111, 1'b0);
    run_stream("reset_mid", 0, acc);
  endtask

  task automatic test_random();
    int acc;
    for (int i = 0; i < 40; i++)
      add_word(NB*W'($urandom), NB'($urandom), 1'($urandom));
    run_stream("random", 2, acc);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_partial_last();
    test_degenerate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axis_serializer.md
Name: axis_serializer

Overview:
- Wide-to-narrow AXI-Stream width converter; the transmit-side counterpart of axis_deserializer.
- Accepts one word of DATA_NB slots of DATA_WIDTH bits on the upstream port.
- Emits the slots one per handshake on the downstream port, slot 0 (bits [DATA_WIDTH-1:0]) first.
- Supports partial final words through a slot-keep mask so that deserializer streams with unaligned last round-trip exactly.

Parameters:
DATA_NB, 3, number of DATA_WIDTH slots per upstream word (>=2)
DATA_WIDTH, 8, width of one slot and of the downstream data bus

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
up_data  in  DATA_NB*DATA_WIDTH  upstream word, slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
up_keep  in  DATA_NB  slot-valid mask, contiguous from bit 0; qualifies up_data
up_valid  in  1  upstream valid
up_ready  out  1  upstream ready
up_last  in  1  upstream end-of-packet, qualifies the word
down_data  out  DATA_WIDTH  downstream slot, registered
down_valid  out  1  downstream valid, registered
down_ready  in  1  downstream ready
down_last  out  1  asserted on the final emitted slot of an up_last word, registered

Behaviour:
- Transfers occur on an edge where valid && ready.
- Reset values (rst low):
  - down_valid=0, down_last=0, down_data=0, slot index=0.
  - Held word and count cleared; up_ready forced 0.
- Mid-operation reset: the held word and any partially emitted slots are discarded. After release, up_ready=1 on the first cycle.
- Internal state:
  - word register (DATA_NB*DATA_WIDTH).
  - slot index idx and slot count n, each clog2(DATA_NB) bits, min 1.
  - last flag, busy flag (IDLE when busy=0, SHIFT when busy=1).
- Slot count n = number of contiguous ones in up_keep starting at bit 0. Examples: 3'b011 -> 2; 3'b101 -> 1; 3'b000 -> 1, so slot 0 is always emitted and there is no deadlock.
- up_ready = rst && (!busy || (down_ready && down_valid && idx==n-1)). Combinational from registers and down_ready, so back-to-back words incur no bubble.
- On upstream accept:
  - Load word, n, last; set idx=0, busy=1.
  - Next cycle: down_valid=1, down_data=slot 0, down_last=(last && n==1).
  - Latency: one clock from up handshake to first down_valid.
- On down handshake with idx<n-1:
  - idx+1; down_data = slot idx+1.
  - down_last = last && (idx+1 == n-1).
- On down handshake with idx==n-1:
  - If an upstream accept happens on the same edge, load the new word (IDLE is never entered).
  - Otherwise busy=0, down_valid=0, down_last=0.
- Backpressure: while down_valid && !down_ready, down_data, down_last and idx are held stable (AXIS rule).
- down_valid never depends combinationally on down_ready.
- Throughput: one slot per cycle with down_ready held high. up_ready pulses once every n cycles.
- up_keep and up_last are sampled only at the upstream handshake. Mid-word upstream changes have no effect.

Decomposition:
- Shared package axis_pkg holds:
  - clog2 constant function.
  - slot-index width constant SLOT_W = clog2(DATA_NB), min 1.
  - Leading-ones count function used to derive n from up_keep (also reusable by axis_deserializer for its keep output).
- No sub-module is needed: a single always block for the data path and one for control, within roughly 150-250 lines.

Test Plan (DATA_NB=3, DATA_WIDTH=8):
1. Reset: hold rst=0 for 6 cycles with up_valid=1 -> up_ready=0 and down_valid=0 throughout. After release, up_ready=1 and no output appears until the first accept.
2. Continuous: words 0x030201, 0x060504, keep=3'b111, down_ready=1 -> down_data 01,02,03,04,05,06 on consecutive cycles. up_ready high only in the cycles ending each word; no bubble between 03 and 04.
3. Backpressure: same stream, down_ready toggled 1,0,0,1,0,1 -> every byte 01..06 emitted exactly once, in order. down_data is stable whenever down_valid && !down_ready.
4. Partial last: word 0x000B0A with keep=3'b011 and up_last=1, followed by word 0x0E0D0C with keep=3'b111 -> 0A,0B,0C,0D,0E. down_last=1 only on 0B.
5. Degenerate keep: word 0x3F2F1F with keep=3'b000 and last=1 -> single output 1F with down_last=1. Word with keep=3'b101 -> single output (slot 0 only).
6. Reset mid-word: word 0x030201 accepted, 01 consumed, rst pulsed low -> down_valid=0 immediately. After release, the next word 0x090807 yields 07,08,09, with no 02 or 03 emitted.
